id_ex_stage_reg: RTL

//  ID/EX pipeline register with integrated load-use hazard detection. Captures the decoded

---
 rtl/id_ex_stage_reg.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//   ID/EX pipeline register with integrated load-use hazard detection.
//   Captures the decoded instruction from ID and presents it to EX and the
//   forwarding unit. It inserts a bubble on a load-use hazard or a flush, and
//   it holds its contents while ext_stall is asserted.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   id_*                decoded instruction from the ID stage
//   flush               squash ID/EX contents (EX branch/jump redirect)
//   ext_stall           downstream hold; all id_ex_* outputs freeze
//   load_use_stall      combinational; IF and IF/ID must hold this cycle
//   id_ex_*             registered copies of the id_* fields
//   perf_lu_bubbles     load-use bubble count (only with the optional feature)
//   perf_fl_bubbles     flush bubble count (only with the optional feature)
//
// Configuration
//   ID_EX_PERF_EN       when defined, builds the two wrapping 32-bit bubble
//                       counters. When undefined, both perf ports read 0.
module id_ex_stage_reg #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_W         = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [XLEN-1:0]           id_pc,
  input  logic [XLEN-1:0]           id_rs1_data,
  input  logic [XLEN-1:0]           id_rs2_data,
  input  logic [XLEN-1:0]           id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic                      id_reg_wr,
  input  logic                      id_mem_rd,
  input  logic                      id_mem_wr,
  input  logic [CTRL_W-1:0]         id_ctrl,
  input  logic                      flush,
  input  logic                      ext_stall,
  output logic                      load_use_stall,
  output logic                      id_ex_valid,
  output logic [XLEN-1:0]           id_ex_pc,
  output logic [XLEN-1:0]           id_ex_rs1_data,
  output logic [XLEN-1:0]           id_ex_rs2_data,
  output logic [XLEN-1:0]           id_ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rs1_addr,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rs2_addr,
  output logic [REG_ADDR_WIDTH-1:0] id_ex_rd_addr,
  output logic                      id_ex_reg_wr,
  output logic                      id_ex_mem_rd,
  output logic                      id_ex_mem_wr,
  output logic [CTRL_W-1:0]         id_ex_ctrl,
  output logic [31:0]               perf_lu_bubbles,
  output logic [31:0]               perf_fl_bubbles
);

  logic rs1_hit;
  logic rs2_hit;
  logic bubble;
  logic hold;

  // A load in EX whose destination (not x0) is read by the valid ID
  // instruction. A flush in the same cycle makes the stall pointless.
  always_comb begin
    rs1_hit        = id_uses_rs1 && (id_rs1_addr == id_ex_rd_addr);
    rs2_hit        = id_uses_rs2 && (id_rs2_addr == id_ex_rd_addr);
    load_use_stall = id_ex_valid && id_ex_mem_rd && (id_ex_rd_addr != '0) &&
                     id_valid && (rs1_hit || rs2_hit) && !flush;
  end

  // flush beats ext_stall. During ext_stall, the load-use bubble is deferred
  // because the stage holds its contents.
  always_comb begin
    bubble = flush || (!ext_stall && load_use_stall);
    hold   = !flush && ext_stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1_addr <= '0;
      id_ex_rs2_addr <= '0;
      id_ex_rd_addr  <= '0;
      id_ex_reg_wr   <= 1'b0;
      id_ex_mem_rd   <= 1'b0;
      id_ex_mem_wr   <= 1'b0;
      id_ex_ctrl     <= '0;
    end else if (bubble) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1_addr <= '0;
      id_ex_rs2_addr <= '0;
      id_ex_rd_addr  <= '0;
      id_ex_reg_wr   <= 1'b0;
      id_ex_mem_rd   <= 1'b0;
      id_ex_mem_wr   <= 1'b0;
      id_ex_ctrl     <= '0;
    end else if (!hold) begin
      // An invalid slot still copies its fields. Its side-effect strobes are
      // masked so it can never write the register file or memory.
      id_ex_valid    <= id_valid;
      id_ex_pc       <= id_pc;
      id_ex_rs1_data <= id_rs1_data;
      id_ex_rs2_data <= id_rs2_data;
      id_ex_imm      <= id_imm;
      id_ex_rs1_addr <= id_rs1_addr;
      id_ex_rs2_addr <= id_rs2_addr;
      id_ex_rd_addr  <= id_rd_addr;
      id_ex_reg_wr   <= id_reg_wr && id_valid;
      id_ex_mem_rd   <= id_mem_rd && id_valid;
      id_ex_mem_wr   <= id_mem_wr && id_valid;
      id_ex_ctrl     <= id_ctrl;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] lu_cnt;
  logic [31:0] fl_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      if (load_use_stall && !ext_stall)
        lu_cnt <= lu_cnt + 32'd1;
      if (flush && (id_ex_valid || id_valid))
        fl_cnt <= fl_cnt + 32'd1;
    end
  end

  always_comb begin
    perf_lu_bubbles = lu_cnt;
    perf_fl_bubbles = fl_cnt;
  end
`else
  always_comb begin
    perf_lu_bubbles = '0;
    perf_fl_bubbles = '0;
  end
`endif

endmodule
